wide_add_seq: RTL and testbench

- Multi-precision add sequencer sitting directly upstream of the 32-bit two-operand adder (no carry-in, carry-out C32).
- Accepts WORDS*32-bit operand pairs over a valid/ready handshake and slices them into 32-bit words, least significant first.
- Drives the external adder with each word pair and folds the inter-word carry in with a second "increment" pass through the same adder.
- Returns the full-width sum and final carry over a valid/ready output handshake.

---
 rtl/wide_add_seq.sv | 98 +++++++++
 tb/tb_wide_add_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-word add sequencer driving an external 32-bit adder, carry folded via an increment pass
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*WORDS-1:0] in_a,
  input  logic [32*WORDS-1:0] in_b,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  input  logic [31:0]         add_s,
  input  logic                add_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*WORDS-1:0] sum,
  output logic                cout
);
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;
  state_t state, state_n;
  logic [WORDS-1:0][31:0] a_r, b_r, sum_r;
  logic [IW-1:0] idx;
  logic [31:0] tmp;
  logic carry, ctmp, cout_r, last;
  assign last = idx == IW'(WORDS-1);
  assign sum = sum_r;
  assign cout = cout_r;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    add_a = '0;
    add_b = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        state_n = in_valid ? ADD : IDLE;
      end
      ADD: begin
        add_a = a_r[idx];
        add_b = b_r[idx];
        state_n = carry ? INC : last ? DONE : ADD;
      end
      INC: begin
        add_a = tmp;
        add_b = 32'd1;
        state_n = last ? DONE : ADD;
      end
      default: begin
        out_valid = 1'b1;
        state_n = out_ready ? IDLE : DONE;
      end
    endcase
  end
  // an incoming carry defers the word store to the INC pass; INC carry and first-pass carry are exclusive
  always_ff @(posedge clk)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      tmp <= '0;
      ctmp <= 1'b0;
      cout_r <= 1'b0;
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            a_r <= in_a;
            b_r <= in_b;
            idx <= '0;
            carry <= 1'b0;
          end
        ADD:
          if (carry) begin
            tmp <= add_s;
            ctmp <= add_c;
          end else begin
            sum_r[idx] <= add_s;
            carry <= add_c;
            if (last) cout_r <= add_c;
            else idx <= idx + 1'b1;
          end
        INC: begin
          sum_r[idx] <= add_s;
          carry <= ctmp | add_c;
          if (last) cout_r <= ctmp | add_c;
          else idx <= idx + 1'b1;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: scoreboard bench for wide_add_seq with an exact 32-bit adder model
module tb_wide_add_seq;
  localparam int WORDS = 4;
  localparam int W = 32 * WORDS;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, cout, add_c;
  logic [31:0] add_a, add_b, add_s;
  logic [W-1:0] sum;
  typedef struct { logic [W-1:0] s; logic c; int lat; int acc; } exp_t;
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0, rmode = 0;
  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c(add_c),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    for (int i = 1; i < WORDS; i++) begin
      logic [W-1:0] m;
      logic [W:0] s;
      m = {W{1'b1}} >> (W - 32 * i);
      s = {1'b0, a & m} + {1'b0, b & m};
      if (s[32*i]) n++;
    end
    return WORDS + n;
  endfunction
  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) begin
      int k = $urandom_range(0, 3);
      v[32*i +: 32] = k == 0 ? 32'hFFFF_FFFF : k == 1 ? 32'h0 : $urandom;
    end
    return v;
  endfunction
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    logic [W:0] full;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout("accept");
    else begin
      full = {1'b0, a} + {1'b0, b};
      q.push_back('{full[W-1:0], full[W], exp_lat(a, b), cyc + 1});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("drain");
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  initial begin
    bit pov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pov = 1'b0;
      else begin
        if (out_valid) begin
          if (q.size() == 0) chk("unexpected_out_valid", {W'(0), out_valid}, 0);
          else begin
            chk("sum", {1'b0, sum}, {1'b0, q[0].s});
            chk("cout", cout, q[0].c);
            chk("in_ready_busy", in_ready, 0);
            chk("adder_zero_done", {add_a, add_b}, 0);
            if (!pov) chk("latency", cyc - q[0].acc, q[0].lat);
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_ready) chk("adder_zero_idle", {add_a, add_b}, 0);
        pov = out_valid;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] ones;
    int n;
    ones = '1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum_cout", {cout, sum}, 0);
    chk("rst_adder", {add_a, add_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    send(W'(1), W'(2));
    wait_idle();
    send(W'(32'hFFFF_FFFF), W'(1));
    wait_idle();
    send(ones, W'(1));
    wait_idle();
    send(ones, ones);
    wait_idle();
    rmode = 1;
    for (int i = 0; i < 40; i++) send(rnd_op(), rnd_op());
    rmode = 0;
    wait_idle();
    rmode = 2;
    send(rnd_op(), rnd_op());
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("bp_out_valid");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = rnd_op();
      in_b = rnd_op();
      @(negedge clk);
    end
    in_valid = 1'b0;
    rmode = 0;
    n = 0;
    while (out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) timeout("bp_release");
    chk("bp_in_ready_after", in_ready, 1);
    send(ones, W'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum_cout", {cout, sum}, 0);
    rst = 1'b0;
    @(negedge clk);
    send(W'(5), W'(7));
    wait_idle();
    chk("post_rst_sum", {cout, sum}, 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
